// File: rtl/ex_bitfield_arbiter.sv
// ex_bitfield_arbiter: round-robin share of one EXT/INS datapath between two pipes with held results.
module ex_ext_ins (
  input  logic [31:0] inst,
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  output logic [31:0] ext,
  output logic [31:0] ins
);
  logic [4:0] msb, lsb;
  logic [31:0] ext_mask, ins_mask;
  assign msb = inst[15:11];
  assign lsb = inst[10:6];
  assign ext_mask = {32{1'b1}} >> (5'd31 - msb);
  assign ins_mask = ({32{1'b1}} << lsb) & ({32{1'b1}} >> (5'd31 - msb));
  assign ext = (in1 >> lsb) & ext_mask;
  assign ins = (in2 & ~ins_mask) | ((in1 << lsb) & ins_mask);
endmodule

module ex_bitfield_arbiter #(
  parameter int NPIPE = 2,
  parameter int WIDTH = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NPIPE-1:0]            req_valid,
  output logic [NPIPE-1:0]            req_ready,
  input  logic [NPIPE-1:0]            req_is_ins,
  input  logic [NPIPE-1:0][31:0]      req_inst,
  input  logic [NPIPE-1:0][WIDTH-1:0] req_in1,
  input  logic [NPIPE-1:0][WIDTH-1:0] req_in2,
  input  logic [NPIPE-1:0]            flush,
  output logic [NPIPE-1:0]            resp_valid,
  output logic [NPIPE-1:0][WIDTH-1:0] resp_data,
  input  logic [NPIPE-1:0]            resp_ack
);
  typedef enum logic {EMPTY, FULL} buf_t;
  logic rr, sel;
  logic [NPIPE-1:0] elig, grant;
  logic [WIDTH-1:0] ext, ins, res;
  assign elig = req_valid & ~flush & (~resp_valid | resp_ack);
  assign grant = !rst_n ? '0 : &elig ? (rr ? 2'b10 : 2'b01) : elig;
  assign req_ready = grant;
  assign sel = grant[1];
  ex_ext_ins u_ext_ins (
    .inst(req_inst[sel]),
    .in1 (req_in1[sel]),
    .in2 (req_in2[sel]),
    .ext (ext),
    .ins (ins)
  );
  assign res = req_is_ins[sel] ? ins : ext;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rr <= 1'b0;
    else if (&elig) rr <= ~rr;
  for (genvar g = 0; g < NPIPE; g++) begin : g_buf
    buf_t st, st_nx;
    logic [WIDTH-1:0] d;
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) st <= EMPTY;
      else st <= st_nx;
    always_comb st_nx = flush[g] ? EMPTY : grant[g] ? FULL : resp_ack[g] ? EMPTY : st;
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) d <= '0;
      else if (grant[g]) d <= res;
    assign resp_valid[g] = st == FULL;
    assign resp_data[g] = d;
  end
endmodule

// File: tb/tb_ex_bitfield_arbiter.sv
// tb_ex_bitfield_arbiter: directed plan scenarios plus random traffic against a bit-level reference model.
module tb_ex_bitfield_arbiter;
  logic clk = 0, rst_n = 0;
  logic [1:0] req_valid = 0, req_ready, req_is_ins = 0, flush = 0, resp_valid, resp_ack = 0;
  logic [1:0][31:0] req_inst = '0, req_in1 = '0, req_in2 = '0, resp_data;
  int total = 0, bad = 0;
  logic [1:0] mv = 0, obs_rdy;
  logic [31:0] md [2];
  logic mrr = 0;
  always #5 clk = ~clk;

  ex_bitfield_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_is_ins(req_is_ins), .req_inst(req_inst), .req_in1(req_in1), .req_in2(req_in2),
    .flush(flush), .resp_valid(resp_valid), .resp_data(resp_data), .resp_ack(resp_ack)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] rf(input logic is_ins, input logic [31:0] inst, a, b);
    int msb = int'(inst[15:11]);
    int lsb = int'(inst[10:6]);
    logic [31:0] r = '0;
    for (int i = 0; i < 32; i++) begin
      if (is_ins) begin
        r[i] = b[i];
        if (i >= lsb && i <= msb) r[i] = a[i - lsb];
      end else if (i <= msb && i + lsb < 32) r[i] = a[i + lsb];
    end
    return r;
  endfunction

  // one clock: drive at negedge, check grant, advance model at posedge, check held results
  task automatic cyc(input logic [1:0] v, ii, ak, fl, input logic [31:0] i0, a0, b0, i1, a1, b1);
    int n;
    int win;
    logic [1:0] g;
    logic [1:0] e;
    req_valid = v; req_is_ins = ii; resp_ack = ak; flush = fl;
    req_inst[0] = i0; req_in1[0] = a0; req_in2[0] = b0;
    req_inst[1] = i1; req_in1[1] = a1; req_in2[1] = b1;
    #1;
    n = 0; win = -1; e = 0;
    for (int p = 0; p < 2; p++)
      if (v[p] && !fl[p] && (!mv[p] || ak[p])) begin n++; win = p; e[p] = 1; end
    g = 0;
    if (n == 2) g[int'(mrr)] = 1;
    else if (n == 1) g[win] = 1;
    obs_rdy = req_ready;
    chk("ready", req_ready, g);
    @(posedge clk);
    if (n == 2) mrr = ~mrr;
    for (int p = 0; p < 2; p++)
      if (fl[p]) mv[p] = 0;
      else if (g[p]) begin
        mv[p] = 1;
        md[p] = rf(ii[p], p ? i1 : i0, p ? a1 : a0, p ? b1 : b0);
      end else if (ak[p]) mv[p] = 0;
    @(negedge clk);
    chk("valid", resp_valid, mv);
    for (int p = 0; p < 2; p++) if (mv[p]) chk("data", resp_data[p], md[p]);
  endtask

  logic [31:0] r0, r1, r2, r3, r4, r5, held;
  logic [1:0] pv = 0, pins = 0, ak, fl;
  logic [31:0] pi [2], pa [2], pb [2];
  logic [1:0] alt [4] = '{2'b01, 2'b10, 2'b01, 2'b10};

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", resp_valid, 0);
    chk("rst_data0", resp_data[0], 0);
    chk("rst_data1", resp_data[1], 0);
    chk("rst_ready", req_ready, 0);
    rst_n = 1;
    for (int k = 0; k < 4; k++) begin
      cyc(2'b11, 2'b00, 2'b11, 0, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
      chk("alt", obs_rdy, alt[k]);
    end
    cyc(0, 0, 2'b11, 0, 0, 0, 0, 0, 0, 0);
    cyc(2'b01, 2'b00, 0, 0, {16'h0, 5'd7, 5'd4, 6'h0}, 32'h12345678, 32'hdeadbeef, 0, 0, 0);
    chk("ext_rdy", obs_rdy, 2'b01);
    chk("ext_data", resp_data[0], 32'h00000067);
    cyc(2'b10, 2'b10, 2'b01, 0, 0, 0, 0, {16'h0, 5'd15, 5'd8, 6'h0}, 32'h000000ab, 32'h11223344);
    chk("ins_data", resp_data[1], 32'h1122ab44);
    r0 = $urandom; r1 = $urandom; r2 = $urandom;
    cyc(2'b01, 2'b00, 2'b10, 0, r0, r1, r2, 0, 0, 0);
    held = resp_data[0];
    for (int k = 0; k < 5; k++) begin
      cyc(2'b01, 2'b01, 0, 0, r0 ^ 32'h5a5, r1, r2, 0, 0, 0);
      chk("hold_rdy", obs_rdy, 0);
      chk("hold_data", resp_data[0], held);
    end
    cyc(2'b01, 2'b01, 2'b01, 0, {16'h0, 5'd23, 5'd4, 6'h0}, 32'h00000abc, 32'hffffffff, 0, 0, 0);
    chk("b2b_rdy", obs_rdy, 2'b01);
    chk("b2b_data", resp_data[0], 32'hff00abcf);
    cyc(2'b10, 0, 2'b01, 0, 0, 0, 0, $urandom, $urandom, $urandom);
    cyc(2'b11, 0, 0, 2'b10, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
    chk("fl_rdy", obs_rdy, 2'b01);
    chk("fl_valid1", resp_valid[1], 0);
    cyc(2'b11, 0, 2'b11, 0, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
    chk("fl_rr", obs_rdy, 2'b01);
    cyc(2'b01, 0, 2'b11, 0, $urandom, $urandom, $urandom, 0, 0, 0);
    cyc(2'b10, 0, 0, 0, 0, 0, 0, $urandom, $urandom, $urandom);
    chk("full", resp_valid, 2'b11);
    req_valid = 2'b11; resp_ack = 0;
    #2 rst_n = 0;
    #1;
    chk("arst_valid", resp_valid, 0);
    chk("arst_ready", req_ready, 0);
    mv = 0; mrr = 0;
    @(negedge clk);
    rst_n = 1;
    cyc(2'b11, 0, 0, 0, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
    chk("arst_first", obs_rdy, 2'b01);
    for (int k = 0; k < 400; k++) begin
      for (int p = 0; p < 2; p++)
        if (!pv[p]) begin
          pv[p] = 1'($urandom);
          pins[p] = 1'($urandom);
          pi[p] = $urandom; pa[p] = $urandom; pb[p] = $urandom;
        end
      ak = 2'($urandom);
      fl = {($urandom_range(7) == 0), ($urandom_range(7) == 0)};
      cyc(pv, pins, ak, fl, pi[0], pa[0], pb[0], pi[1], pa[1], pb[1]);
      pv = pv & ~obs_rdy & ~fl;
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
